// File: rtl/multicycle_control_unit.sv
// Multicycle CPU main-control FSM with ALU-select decode, memory request/ready
// handshake with bounded wait, fetch stall, and halt/illegal/bus-error status.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int ALUSEL_W    = 3,
  parameter int ALU_ADD     = 0,
  parameter int ALU_SUB     = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                Clk_i,
  input  logic                Reset_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                MemReady_i,
  input  logic                Stall_i,
  output logic                MemReq_o,
  output logic                PCWrite_o,
  output logic                PCWriteCond_o,
  output logic                RegRead_o,
  output logic                MemAddr_o,
  output logic                MemWrite_o,
  output logic                IRWrite_o,
  output logic                ALUSrcA_o,
  output logic                RegWrite_o,
  output logic [1:0]          MemtoReg_o,
  output logic [1:0]          BranchCond_o,
  output logic [1:0]          PCSource_o,
  output logic [1:0]          ALUSrcB_o,
  output logic [ALUSEL_W-1:0] ALUSelect_o,
  output logic                InstrRetired_o,
  output logic                Halted_o,
  output logic                IllegalOp_o,
  output logic                BusError_o,
  output logic [3:0]          State_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam int CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [ALUSEL_W-1:0] SEL_ADD = ALUSEL_W'(ALU_ADD);
  localparam logic [ALUSEL_W-1:0] SEL_SUB = ALUSEL_W'(ALU_SUB);

  logic [3:0]          state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ALUSEL_W-1:0] func_q, func_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic                mem_req;
  logic [2:0]          op_class;

  assign op_class = opcode_i[OPCODE_W-1 -: 3];

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    func_d         = func_q;
    illegal_d      = illegal_q;
    bus_err_d      = bus_err_q;
    mem_req        = 1'b0;
    PCWrite_o      = 1'b0;
    PCWriteCond_o  = 1'b0;
    RegRead_o      = 1'b0;
    MemAddr_o      = 1'b0;
    MemWrite_o     = 1'b0;
    IRWrite_o      = 1'b0;
    ALUSrcA_o      = 1'b0;
    RegWrite_o     = 1'b0;
    MemtoReg_o     = 2'b00;
    BranchCond_o   = 2'b00;
    PCSource_o     = 2'b00;
    ALUSrcB_o      = 2'b00;
    ALUSelect_o    = '0;
    InstrRetired_o = 1'b0;
    Halted_o       = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB_o   = 2'b01;
        ALUSelect_o = SEL_ADD;
        // Once a request is outstanding the stall can no longer withdraw it.
        mem_req     = !Stall_i || (wait_cnt_q != '0);
        if (mem_req && MemReady_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        RegRead_o   = 1'b1;
        ALUSrcB_o   = 2'b11;
        ALUSelect_o = SEL_ADD;
        func_d      = opcode_i[ALUSEL_W-1:0];
        case (op_class)
          3'b000:          state_d = S_EXEC_R;
          3'b001:          state_d = S_EXEC_I;
          3'b010, 3'b011:  state_d = S_MEM_ADDR;
          3'b100:          state_d = S_BRANCH;
          3'b101:          state_d = S_JUMP;
          3'b110:          state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA_o   = 1'b1;
        ALUSrcB_o   = (state_q == S_EXEC_I) ? 2'b10 : 2'b00;
        ALUSelect_o = func_q;
        state_d     = S_WB_ALU;
      end
      S_WB_ALU, S_WB_MEM: begin
        RegWrite_o     = 1'b1;
        MemtoReg_o     = (state_q == S_WB_MEM) ? 2'b01 : 2'b00;
        InstrRetired_o = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA_o   = 1'b1;
        ALUSrcB_o   = 2'b10;
        ALUSelect_o = SEL_ADD;
        // Class bit 0 of the latched opcode separates load from store.
        state_d     = opcode_i[OPCODE_W-3] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemAddr_o = 1'b1;
        mem_req   = 1'b1;
        if (MemReady_i) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        MemAddr_o  = 1'b1;
        MemWrite_o = 1'b1;
        mem_req    = 1'b1;
        if (MemReady_i) begin
          InstrRetired_o = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUSrcA_o      = 1'b1;
        ALUSelect_o    = SEL_SUB;
        PCWriteCond_o  = 1'b1;
        BranchCond_o   = func_q[1:0];
        PCSource_o     = 2'b01;
        InstrRetired_o = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        PCWrite_o      = 1'b1;
        PCSource_o     = 2'b10;
        MemtoReg_o     = 2'b10;
        RegWrite_o     = func_q[0];
        InstrRetired_o = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT:  Halted_o = 1'b1;
      default: state_d  = S_FETCH;
    endcase

    if (mem_req) begin
      if (MemReady_i) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        wait_cnt_d = '0;
        bus_err_d  = 1'b1;
        state_d    = S_HALT;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      func_q     <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      func_q     <= func_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign MemReq_o    = mem_req;
  assign IllegalOp_o = illegal_q;
  assign BusError_o  = bus_err_q;
  assign State_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: instruction-level model emits the expected control vector
// for every cycle; a monitor compares them against the DUT on the falling edge.
module tb_multicycle_control_unit;

  localparam int OPW         = 6;
  localparam int ASW         = 3;
  localparam int ALU_ADD     = 0;
  localparam int ALU_SUB     = 1;
  localparam int MEM_TIMEOUT = 16;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_read;
    logic       mem_addr;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] branch_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       retired;
    logic       halted;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stall = 1'b0;
  logic           rdy = 1'b0;
  logic [OPW-1:0] opcode = '0;

  logic           mem_req, pc_write, pc_write_cond, reg_read, mem_addr;
  logic           mem_write, ir_write, alu_src_a, reg_write;
  logic [1:0]     mem_to_reg, branch_cond, pc_source, alu_src_b;
  logic [ASW-1:0] alu_sel;
  logic           retired, halted, illegal, bus_err;
  logic [3:0]     state;

  multicycle_control_unit #(
    .OPCODE_W(OPW), .ALUSEL_W(ASW), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .Clk_i(clk), .Reset_i(rst), .opcode_i(opcode), .MemReady_i(rdy),
    .Stall_i(stall), .MemReq_o(mem_req), .PCWrite_o(pc_write),
    .PCWriteCond_o(pc_write_cond), .RegRead_o(reg_read), .MemAddr_o(mem_addr),
    .MemWrite_o(mem_write), .IRWrite_o(ir_write), .ALUSrcA_o(alu_src_a),
    .RegWrite_o(reg_write), .MemtoReg_o(mem_to_reg),
    .BranchCond_o(branch_cond), .PCSource_o(pc_source), .ALUSrcB_o(alu_src_b),
    .ALUSelect_o(alu_sel), .InstrRetired_o(retired), .Halted_o(halted),
    .IllegalOp_o(illegal), .BusError_o(bus_err), .State_o(state)
  );

  always #5 clk = ~clk;

  ctl_t act;
  assign act = {state, mem_req, pc_write, pc_write_cond, reg_read, mem_addr,
                mem_write, ir_write, alu_src_a, reg_write, mem_to_reg,
                branch_cond, pc_source, alu_src_b, alu_sel, retired, halted,
                illegal, bus_err};

  ctl_t exp_q[$];
  ctl_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: one expected vector per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (act !== mon_e) begin
        miscompares++;
        $display("FAIL ctl_vec #%0d: got %h (state %0d) expected %h (state %0d)",
                 vectors, act, act.state, mon_e, mon_e.state);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  function automatic ctl_t idle(input int st);
    ctl_t c = '0;
    c.state = 4'(st);
    return c;
  endfunction

  function automatic ctl_t fetch_v(input logic req, input logic done);
    ctl_t c = idle(0);
    c.alu_src_b = 2'b01;
    c.alu_sel   = 3'(ALU_ADD);
    c.mem_req   = req;
    c.ir_write  = done;
    c.pc_write  = done;
    return c;
  endfunction

  function automatic ctl_t halt_v(input logic ill, input logic be);
    ctl_t c = idle(11);
    c.halted  = 1'b1;
    c.illegal = ill;
    c.bus_err = be;
    return c;
  endfunction

  task automatic step(input logic r, input logic s, input logic m, input ctl_t e);
    rst   = r;
    stall = s;
    rdy   = m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Parked in HALT with inputs toggling, then released by reset.
  task automatic halt_then_reset(input logic ill, input logic be);
    repeat (3) step(1'b0, rb(), rb(), halt_v(ill, be));
    step(1'b1, rb(), rb(), halt_v(ill, be));
  endtask

  // One instruction: stall_n stalled fetch cycles, fw fetch wait cycles, mw
  // memory wait cycles (mw >= MEM_TIMEOUT means memory never answers);
  // rst_mid asserts reset on the last memory wait cycle.
  task automatic run_instr(input logic [OPW-1:0] op, input int stall_n,
                           input int fw, input int mw, input bit rst_mid);
    logic [2:0] cls  = op[OPW-1 -: 3];
    logic [2:0] func = op[ASW-1:0];
    ctl_t c;
    opcode = op;
    for (int i = 0; i < stall_n; i++) step(1'b0, 1'b1, rb(), fetch_v(1'b0, 1'b0));
    for (int i = 0; i < fw; i++)
      step(1'b0, (i == 0) ? 1'b0 : rb(), 1'b0, fetch_v(1'b1, 1'b0));
    step(1'b0, (fw > 0) ? rb() : 1'b0, 1'b1, fetch_v(1'b1, 1'b1));
    c = idle(1); c.reg_read = 1'b1; c.alu_src_b = 2'b11; c.alu_sel = 3'(ALU_ADD);
    step(1'b0, rb(), rb(), c);
    case (cls)
      3'd0, 3'd1: begin
        c = idle((cls == 3'd0) ? 2 : 3);
        c.alu_src_a = 1'b1;
        c.alu_src_b = (cls == 3'd0) ? 2'b00 : 2'b10;
        c.alu_sel   = func;
        step(1'b0, rb(), rb(), c);
        c = idle(7); c.reg_write = 1'b1; c.retired = 1'b1;
        step(1'b0, rb(), rb(), c);
      end
      3'd2, 3'd3: begin
        c = idle(4); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_sel = 3'(ALU_ADD);
        step(1'b0, rb(), rb(), c);
        c = idle((cls == 3'd2) ? 5 : 6);
        c.mem_addr  = 1'b1;
        c.mem_req   = 1'b1;
        c.mem_write = (cls == 3'd3);
        if (mw >= MEM_TIMEOUT) begin
          repeat (MEM_TIMEOUT) step(1'b0, rb(), 1'b0, c);
          halt_then_reset(1'b0, 1'b1);
          return;
        end
        for (int i = 0; i < mw; i++) begin
          if (rst_mid && i == mw - 1) begin
            step(1'b1, rb(), 1'b0, c);
            return;
          end
          step(1'b0, rb(), 1'b0, c);
        end
        c.retired = (cls == 3'd3);
        step(1'b0, rb(), 1'b1, c);
        if (cls == 3'd2) begin
          c = idle(8); c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.retired = 1'b1;
          step(1'b0, rb(), rb(), c);
        end
      end
      3'd4: begin
        c = idle(9);
        c.alu_src_a     = 1'b1;
        c.alu_sel       = 3'(ALU_SUB);
        c.pc_write_cond = 1'b1;
        c.branch_cond   = func[1:0];
        c.pc_source     = 2'b01;
        c.retired       = 1'b1;
        step(1'b0, rb(), rb(), c);
      end
      3'd5: begin
        c = idle(10);
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.mem_to_reg = 2'b10;
        c.reg_write  = func[0];
        c.retired    = 1'b1;
        step(1'b0, rb(), rb(), c);
      end
      3'd6:    halt_then_reset(1'b0, 1'b0);
      default: halt_then_reset(1'b1, 1'b0);
    endcase
  endtask

  task automatic fetch_timeout();
    opcode = 6'($urandom);
    for (int i = 0; i < MEM_TIMEOUT; i++)
      step(1'b0, (i == 0) ? 1'b0 : rb(), 1'b0, fetch_v(1'b1, 1'b0));
    halt_then_reset(1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] cls;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_instr(6'b000_010, 0, 0, 0, 1'b0);
    run_instr(6'b010_000, 5, 0, 3, 1'b0);
    run_instr(6'b011_000, 0, 1, 2, 1'b0);
    run_instr(6'b100_001, 0, 0, 0, 1'b0);
    run_instr(6'b101_001, 0, 2, 0, 1'b0);
    run_instr(6'b101_000, 0, 0, 0, 1'b0);
    run_instr(6'b001_110, 1, 0, 0, 1'b0);
    run_instr(6'b011_000, 0, 0, 3, 1'b1);
    run_instr(6'b000_101, 2, MEM_TIMEOUT - 1, 0, 1'b0);
    run_instr(6'b111_000, 0, 0, 0, 1'b0);
    run_instr(6'b110_011, 0, 0, 0, 1'b0);
    fetch_timeout();
    run_instr(6'b010_011, 0, 0, MEM_TIMEOUT, 1'b0);
    run_instr(6'b011_101, 0, 0, MEM_TIMEOUT - 1, 1'b0);
    for (int n = 0; n < 120; n++) begin
      cls = ($urandom % 25 == 0) ? 3'(6 + ($urandom % 2)) : 3'($urandom % 6);
      run_instr({cls, 3'($urandom)}, $urandom % 3, $urandom % 5, $urandom % 5,
                ($urandom % 15) == 0);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected vectors left, required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
